// File: rtl/sim_trace_pkg.sv
// Shared constants and the character FIFO payload type for the trace collector.
package sim_trace_pkg;

  localparam logic [7:0]  NOP_OPCODE = 8'h15;
  localparam logic [15:0] NOP_EXIT   = 16'h0001;
  localparam logic [15:0] NOP_PUTC   = 16'h0004;

  // Wide enough for the largest supported core count (64 cores -> 7 bits).
  localparam int unsigned CORE_ID_W  = 7;

  typedef struct packed {
    logic [7:0]           data;
    logic [CORE_ID_W-1:0] core;
  } char_entry_t;

endpackage

// File: rtl/sim_trace_char_fifo.sv
// Show-ahead FIFO for merged putc characters. Pointers carry one extra wrap bit.
module sim_trace_char_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok_c;
  logic             pop_ok_c;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // Accept a push while full only if the head leaves in the same cycle; no empty bypass.
  always_comb begin
    pop_ok_c  = pop & ~empty;
    push_ok_c = push & (~full | pop_ok_c);
    wr_ptr_d  = push_ok_c ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop_ok_c  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sim_trace_collector.sv
// Per-core retired-instruction trace collector: shadow r3, exit/putc nop decode,
// round-robin merge of putc bytes into one FIFO-buffered stream.
// Optional watchdog output 'timeout' is built when SIM_TRACE_WATCHDOG_EN is defined.
module sim_trace_collector
  import sim_trace_pkg::*;
#(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CORES-1:0]       trace_valid,
  input  logic [32*NUM_CORES-1:0]    trace_insn,
  input  logic [NUM_CORES-1:0]       trace_wben,
  input  logic [5*NUM_CORES-1:0]     trace_wbreg,
  input  logic [32*NUM_CORES-1:0]    trace_wbdata,
  output logic                       char_valid,
  input  logic                       char_ready,
  output logic [7:0]                 char_data,
  output logic [$clog2(NUM_CORES):0] char_core,
  output logic [NUM_CORES-1:0]       terminated,
  output logic [32*NUM_CORES-1:0]    exit_code,
  output logic                       all_done,
`ifdef SIM_TRACE_WATCHDOG_EN
  output logic                       timeout,
`endif
  output logic [NUM_CORES-1:0]       char_drop
);

  localparam int unsigned CW = $clog2(NUM_CORES) + 1;

  logic [NUM_CORES-1:0][31:0] r3_q, r3_d;
  logic [NUM_CORES-1:0][31:0] exit_q, exit_d;
  logic [NUM_CORES-1:0][7:0]  pend_data_q, pend_data_d;
  logic [NUM_CORES-1:0]       term_q, term_d;
  logic [NUM_CORES-1:0]       pend_v_q, pend_v_d;
  logic [NUM_CORES-1:0]       drop_q, drop_d;
  logic [CW-1:0]              last_q, last_d;
  logic                       all_done_q, all_done_d;

  logic [NUM_CORES-1:0]       live_c, is_exit_c, is_putc_c, grant_oh_c;
  logic                       grant_v_c, hi_found_c;
  logic [CW-1:0]              grant_idx_c, hi_idx_c, lo_idx_c;
  logic [7:0]                 grant_data_c, hi_data_c, lo_data_c;
  logic                       fifo_empty, fifo_full, fifo_can_push_c;
  char_entry_t                push_entry_c, head_entry;

  assign fifo_can_push_c = ~fifo_full | (char_valid & char_ready);

  // Decode exit/putc nops from cores that have not yet terminated.
  always_comb begin
    live_c    = trace_valid & ~term_q;
    is_exit_c = '0;
    is_putc_c = '0;
    for (int c = 0; c < int'(NUM_CORES); c++) begin
      if (live_c[c] && (trace_insn[32*c+24 +: 8] == NOP_OPCODE)) begin
        is_exit_c[c] = (trace_insn[32*c +: 16] == NOP_EXIT);
        is_putc_c[c] = (trace_insn[32*c +: 16] == NOP_PUTC);
      end
    end
  end

  // Round-robin pick: lowest pending core above the last grant, else lowest pending overall.
  always_comb begin
    hi_found_c = 1'b0;
    hi_idx_c   = '0;
    lo_idx_c   = '0;
    hi_data_c  = '0;
    lo_data_c  = '0;
    for (int c = int'(NUM_CORES) - 1; c >= 0; c--) begin
      if (pend_v_q[c]) begin
        lo_idx_c  = CW'(c);
        lo_data_c = pend_data_q[c];
        if (CW'(c) > last_q) begin
          hi_found_c = 1'b1;
          hi_idx_c   = CW'(c);
          hi_data_c  = pend_data_q[c];
        end
      end
    end
    grant_v_c    = (|pend_v_q) & fifo_can_push_c;
    grant_idx_c  = hi_found_c ? hi_idx_c  : lo_idx_c;
    grant_data_c = hi_found_c ? hi_data_c : lo_data_c;
    grant_oh_c   = '0;
    for (int c = 0; c < int'(NUM_CORES); c++) begin
      grant_oh_c[c] = grant_v_c && (grant_idx_c == CW'(c));
    end
    push_entry_c.data = grant_data_c;
    push_entry_c.core = CORE_ID_W'(grant_idx_c);
  end

  // Next state for shadow r3, termination, pending bytes, drops and completion.
  always_comb begin
    r3_d        = r3_q;
    exit_d      = exit_q;
    pend_data_d = pend_data_q;
    term_d      = term_q;
    pend_v_d    = pend_v_q;
    drop_d      = drop_q;
    last_d      = grant_v_c ? grant_idx_c : last_q;
    all_done_d  = all_done_q | ((&term_q) & ~(|pend_v_q) & fifo_empty);
    for (int c = 0; c < int'(NUM_CORES); c++) begin
      if (live_c[c] && trace_wben[c] && (trace_wbreg[5*c +: 5] == 5'd3)) begin
        r3_d[c] = trace_wbdata[32*c +: 32];
      end
      if (is_exit_c[c]) begin
        term_d[c] = 1'b1;
        exit_d[c] = r3_q[c];
      end
      if (grant_oh_c[c]) pend_v_d[c] = 1'b0;
      // A grant in the same cycle frees the slot, so the new byte replaces it without a drop.
      if (is_putc_c[c]) begin
        if (pend_v_q[c] && !grant_oh_c[c]) begin
          drop_d[c] = 1'b1;
        end else begin
          pend_v_d[c]    = 1'b1;
          pend_data_d[c] = r3_q[c][7:0];
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_q        <= '0;
      exit_q      <= '0;
      pend_data_q <= '0;
      term_q      <= '0;
      pend_v_q    <= '0;
      drop_q      <= '0;
      last_q      <= CW'(NUM_CORES - 1);
      all_done_q  <= 1'b0;
    end else begin
      r3_q        <= r3_d;
      exit_q      <= exit_d;
      pend_data_q <= pend_data_d;
      term_q      <= term_d;
      pend_v_q    <= pend_v_d;
      drop_q      <= drop_d;
      last_q      <= last_d;
      all_done_q  <= all_done_d;
    end
  end

  sim_trace_char_fifo #(
    .WIDTH ($bits(char_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_char_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant_v_c),
    .push_data (push_entry_c),
    .pop       (char_ready),
    .pop_data  (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign char_valid = ~fifo_empty;
  assign char_data  = head_entry.data;
  assign char_core  = CW'(head_entry.core);
  assign terminated = term_q;
  assign exit_code  = exit_q;
  assign all_done   = all_done_q;
  assign char_drop  = drop_q;

`ifdef SIM_TRACE_WATCHDOG_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  // Idle counter: cleared by any live trace, saturating, frozen after completion.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    if (!all_done_q) begin
      if (|live_c)                wd_cnt_d = '0;
      else if (wd_cnt_q != '1)    wd_cnt_d = wd_cnt_q + 32'd1;
    end
    timeout_d = timeout_q | (wd_cnt_d >= TIMEOUT_CYCLES);
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_sim_trace_collector.sv
`timescale 1ns/1ps
module tb_sim_trace_collector;

  localparam int NC    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 3;
  localparam logic [31:0] PUTC = 32'h15000004;
  localparam logic [31:0] EXIT = 32'h15000001;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     trace_valid, trace_wben;
  logic [32*NC-1:0]  trace_insn, trace_wbdata;
  logic [5*NC-1:0]   trace_wbreg;
  logic              char_valid, char_ready;
  logic [7:0]        char_data;
  logic [CW-1:0]     char_core;
  logic [NC-1:0]     terminated, char_drop;
  logic [32*NC-1:0]  exit_code;
  logic              all_done;
`ifdef SIM_TRACE_WATCHDOG_EN
  logic              timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sim_trace_collector #(.NUM_CORES(NC), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trace_valid  (trace_valid),
    .trace_insn   (trace_insn),
    .trace_wben   (trace_wben),
    .trace_wbreg  (trace_wbreg),
    .trace_wbdata (trace_wbdata),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .char_data    (char_data),
    .char_core    (char_core),
    .terminated   (terminated),
    .exit_code    (exit_code),
    .all_done     (all_done),
`ifdef SIM_TRACE_WATCHDOG_EN
    .timeout      (timeout),
`endif
    .char_drop    (char_drop)
  );

  // Reference model: state described directly by the behavioural rules.
  int unsigned m_r3[NC];
  int unsigned m_exit[NC];
  bit          m_term[NC];
  bit          m_pv[NC];
  int          m_pd[NC];
  bit          m_drop[NC];
  int          m_last;
  int          m_fifo[$];
  bit          m_done;

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_r3[c] = 0; m_exit[c] = 0; m_term[c] = 0; m_pv[c] = 0; m_pd[c] = 0; m_drop[c] = 0;
    end
    m_last = NC - 1;
    m_fifo.delete();
    m_done = 0;
  endfunction

  function automatic void model_step();
    int unsigned r3_old[NC];
    bit pop, can_push, all_t, any_p;
    int g, idx;
    logic [31:0] insn;
    r3_old   = m_r3;
    pop      = (m_fifo.size() > 0) && char_ready;
    can_push = (m_fifo.size() < DEPTH) || pop;
    all_t = 1; any_p = 0;
    for (int c = 0; c < NC; c++) begin
      all_t &= m_term[c];
      any_p |= m_pv[c];
    end
    if (all_t && !any_p && m_fifo.size() == 0) m_done = 1;
    g = -1;
    if (can_push) begin
      for (int k = 1; k <= NC; k++) begin
        idx = (m_last + k) % NC;
        if (g < 0 && m_pv[idx]) g = idx;
      end
    end
    if (pop) void'(m_fifo.pop_front());
    if (g >= 0) begin
      m_fifo.push_back(m_pd[g] | (g << 8));
      m_pv[g] = 0;
      m_last  = g;
    end
    for (int c = 0; c < NC; c++) begin
      if (trace_valid[c] && !m_term[c]) begin
        insn = trace_insn[32*c +: 32];
        if (trace_wben[c] && trace_wbreg[5*c +: 5] == 5'd3) m_r3[c] = trace_wbdata[32*c +: 32];
        if (insn[31:24] == 8'h15 && insn[15:0] == 16'd1) begin
          m_term[c] = 1;
          m_exit[c] = r3_old[c];
        end
        if (insn[31:24] == 8'h15 && insn[15:0] == 16'd4) begin
          if (m_pv[c]) m_drop[c] = 1;
          else begin
            m_pv[c] = 1;
            m_pd[c] = int'(r3_old[c] & 32'hFF);
          end
        end
      end
    end
  endfunction

  task automatic clear_inputs();
    trace_valid = '0; trace_wben = '0; trace_insn = '0; trace_wbreg = '0; trace_wbdata = '0;
  endtask

  task automatic drive_wb(int c, logic [4:0] rg, logic [31:0] v);
    trace_valid[c] = 1'b1;
    trace_wben[c]  = 1'b1;
    trace_wbreg[5*c +: 5]   = rg;
    trace_wbdata[32*c +: 32] = v;
    trace_insn[32*c +: 32]   = 32'hE0600004;
  endtask

  task automatic drive_insn(int c, logic [31:0] insn);
    trace_valid[c] = 1'b1;
    trace_insn[32*c +: 32] = insn;
  endtask

  // Advance one clock, keeping the model in lock-step; returns 1 ns after the edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    char_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL reset_char_valid got %b exp 0", char_valid); end
    checks++; if (terminated !== '0) begin errors++; $display("FAIL reset_terminated got %h exp 0", terminated); end
    checks++; if (exit_code !== '0) begin errors++; $display("FAIL reset_exit_code got %h exp 0", exit_code); end
    checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL reset_all_done got %b exp 0", all_done); end
    checks++; if (char_drop !== '0) begin errors++; $display("FAIL reset_char_drop got %h exp 0", char_drop); end
  endtask

  task automatic test_putc_latency();
    do_reset();
    drive_wb(0, 5'd3, 32'h41); cycle(); clear_inputs();
    drive_insn(0, PUTC); cycle(); clear_inputs();
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL lat_n1_valid got %b exp 0", char_valid); end
    cycle();
    checks++; if (char_valid !== 1'b1) begin errors++; $display("FAIL lat_n2_valid got %b exp 1", char_valid); end
    checks++; if (char_data !== 8'h41) begin errors++; $display("FAIL lat_data got %h exp 41", char_data); end
    checks++; if (char_core !== 3'd0) begin errors++; $display("FAIL lat_core got %0d exp 0", char_core); end
    char_ready = 1'b1; cycle(); char_ready = 1'b0;
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL lat_popped_valid got %b exp 0", char_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < NC; c++) drive_wb(c, 5'd3, 32'h30 + 32'(c));
    cycle(); clear_inputs();
    for (int c = 0; c < NC; c++) drive_insn(c, PUTC);
    char_ready = 1'b1;
    cycle(); clear_inputs();
    for (int i = 0; i < NC; i++) begin
      cycle();
      checks++;
      if (char_valid !== 1'b1 || char_core !== CW'(i) || char_data !== 8'(8'h30 + i)) begin
        errors++;
        $display("FAIL rr_slot%0d got v=%b core=%0d data=%h exp v=1 core=%0d data=%h",
                 i, char_valid, char_core, char_data, i, 8'h30 + i);
      end
    end
    checks++; if (char_drop !== '0) begin errors++; $display("FAIL rr_drop got %h exp 0", char_drop); end
    char_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive_insn(1, PUTC); cycle(); clear_inputs();
    end
    repeat (3) cycle();
    checks++; if (char_drop !== 4'b0010) begin errors++; $display("FAIL bp_drop got %b exp 0010", char_drop); end
    checks++; if (char_valid !== 1'b1 || char_data !== 8'h00 || char_core !== 3'd1) begin
      errors++; $display("FAIL bp_head got v=%b data=%h core=%0d exp v=1 data=00 core=1", char_valid, char_data, char_core);
    end
    char_ready = 1'b1;
    n = 0;
    for (int t = 0; t < 60; t++) begin
      if (char_valid) n++;
      cycle();
    end
    char_ready = 1'b0;
    checks++; if (n != 17) begin errors++; $display("FAIL bp_drain_count got %0d exp 17", n); end
    checks++; if (char_drop !== 4'b0010) begin errors++; $display("FAIL bp_drop_sticky got %b exp 0010", char_drop); end
  endtask

  task automatic test_exit();
    do_reset();
    drive_wb(2, 5'd3, 32'hDEADBEEF); cycle(); clear_inputs();
    drive_insn(2, EXIT); cycle(); clear_inputs();
    checks++; if (terminated !== 4'b0100) begin errors++; $display("FAIL exit_term got %b exp 0100", terminated); end
    checks++; if (exit_code[64 +: 32] !== 32'hDEADBEEF) begin errors++; $display("FAIL exit_code got %h exp deadbeef", exit_code[64 +: 32]); end
    drive_wb(2, 5'd3, 32'h12345678); cycle(); clear_inputs();
    drive_insn(2, PUTC); cycle(); clear_inputs();
    drive_insn(2, EXIT); cycle(); clear_inputs();
    repeat (3) cycle();
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL exit_ignored_putc got %b exp 0", char_valid); end
    checks++; if (exit_code[64 +: 32] !== 32'hDEADBEEF) begin errors++; $display("FAIL exit_code_hold got %h exp deadbeef", exit_code[64 +: 32]); end
    checks++; if (terminated !== 4'b0100) begin errors++; $display("FAIL exit_term_hold got %b exp 0100", terminated); end
  endtask

  task automatic test_all_done();
    do_reset();
    for (int c = 0; c < 3; c++) drive_insn(c, PUTC);
    cycle(); clear_inputs();
    for (int c = 0; c < NC; c++) drive_insn(c, EXIT);
    cycle(); clear_inputs();
    repeat (3) cycle();
    checks++; if (terminated !== 4'hF || all_done !== 1'b0) begin
      errors++; $display("FAIL done_queued got term=%h done=%b exp term=f done=0", terminated, all_done);
    end
    for (int p = 0; p < 3; p++) begin
      char_ready = 1'b1; cycle(); char_ready = 1'b0;
      checks++; if (all_done !== 1'b0) begin errors++; $display("FAIL done_pop%0d got %b exp 0", p, all_done); end
    end
    checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL done_empty got %b exp 0", char_valid); end
    cycle();
    checks++; if (all_done !== 1'b1) begin errors++; $display("FAIL done_rise got %b exp 1", all_done); end
    repeat (2) cycle();
    checks++; if (all_done !== 1'b1) begin errors++; $display("FAIL done_sticky got %b exp 1", all_done); end
  endtask

  task automatic test_random();
    int head;
    logic [NC-1:0] e_term, e_drop;
    logic [32*NC-1:0] e_exit;
    do_reset();
    for (int t = 0; t < 700; t++) begin
      clear_inputs();
      char_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NC; c++) begin
        case ($urandom_range(0, 9))
          0, 1:    drive_wb(c, 5'd3, 32'($urandom_range(32, 126)));
          2:       drive_wb(c, 5'd3, $urandom);
          3, 4, 5: drive_insn(c, PUTC);
          6:       drive_insn(c, ($urandom_range(0, 1) != 0) ? 32'h15000002 : (32'h15000000 | 32'($urandom_range(5, 65535))));
          7:       drive_wb(c, 5'($urandom_range(4, 31)), $urandom);
          9:       if ($urandom_range(0, 99) == 0) drive_insn(c, EXIT);
          default: ;
        endcase
      end
      cycle();
      checks++;
      if (m_fifo.size() > 0) begin
        head = m_fifo[0];
        if (char_valid !== 1'b1 || char_data !== head[7:0] || char_core !== head[CW+7:8]) begin
          errors++;
          $display("FAIL rand_head t=%0d got v=%b data=%h core=%0d exp v=1 data=%h core=%0d",
                   t, char_valid, char_data, char_core, head[7:0], head[CW+7:8]);
        end
      end else if (char_valid !== 1'b0) begin
        errors++; $display("FAIL rand_head t=%0d got v=%b exp v=0", t, char_valid);
      end
    end
    clear_inputs();
    for (int c = 0; c < NC; c++) drive_insn(c, EXIT);
    cycle(); clear_inputs();
    char_ready = 1'b1;
    for (int t = 0; t < 100 && !m_done; t++) cycle();
    cycle();
    char_ready = 1'b0;
    for (int c = 0; c < NC; c++) begin
      e_term[c] = m_term[c];
      e_drop[c] = m_drop[c];
      e_exit[32*c +: 32] = m_exit[c];
    end
    checks++; if (terminated !== e_term) begin errors++; $display("FAIL rand_term got %b exp %b", terminated, e_term); end
    checks++; if (char_drop !== e_drop) begin errors++; $display("FAIL rand_drop got %b exp %b", char_drop, e_drop); end
    checks++; if (exit_code !== e_exit) begin errors++; $display("FAIL rand_exit got %h exp %h", exit_code, e_exit); end
    checks++; if (all_done !== m_done || m_done != 1'b1) begin errors++; $display("FAIL rand_done got %b exp %b", all_done, m_done); end
  endtask

`ifdef SIM_TRACE_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    drive_insn(0, PUTC); cycle(); clear_inputs();
    for (int k = 1; k <= 105; k++) begin
      cycle();
      if (k == 99) begin
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_early got %b exp 0", timeout); end
      end
      if (k == 100) begin
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL wd_fire got %b exp 1", timeout); end
        checks++; if (char_valid !== 1'b1) begin errors++; $display("FAIL wd_fifo got %b exp 1", char_valid); end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (timeout !== 1'b0 || char_valid !== 1'b0) begin
      errors++; $display("FAIL wd_async_reset got timeout=%b valid=%b exp 0 0", timeout, char_valid);
    end
    do_reset();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    char_ready = 1'b0;
    clear_inputs();
    test_reset();
    test_putc_latency();
    test_round_robin();
    test_backpressure();
    test_exit();
    test_all_done();
    test_random();
`ifdef SIM_TRACE_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL sim_time_limit reached without completing");
    $fatal(1);
  end

endmodule
